basket_controller: RTL and testbench

- Owns the shopping-basket storage: a compacted list of up to MAX_ITEMS (ProductID, quantity) entries.
- The sale-terminal state machine issues Add, Cancel and Clear commands as single-cycle pulses. This block sequences each command into a multi-cycle search, merge, append or shift operation on the entry array.
- It reports the entry count back to the state machine and to the Direction2ProductID selector.
- It provides a registered read port for the VGA basket display.

---
 rtl/basket_controller_if.sv | 33 +++
 rtl/basket_controller.sv | 188 ++++++++++++++++++
 tb/tb_basket_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/basket_controller_if.sv
// Command, read-port and status bundle between the sale-terminal FSM / VGA display and the basket store.
interface basket_controller_if;
  logic       Add_Pulse;
  logic       Cancel_Pulse;
  logic       Clear_Pulse;
  logic [3:0] ProductID_in;
  logic [3:0] ProductQuantity_in;
  logic [3:0] Cancel_Index;
  logic [3:0] Rd_Index;
  logic [3:0] Rd_ProductID;
  logic [3:0] Rd_Quantity;
  logic       Rd_Valid;
  logic [3:0] BasketProductNum;
  logic       Busy;
  logic       Done;
  logic       Err_Full;
  logic       Err_Index;
  logic       Drop;

  modport master (
    output Add_Pulse, Cancel_Pulse, Clear_Pulse, ProductID_in, ProductQuantity_in,
           Cancel_Index, Rd_Index,
    input  Rd_ProductID, Rd_Quantity, Rd_Valid, BasketProductNum, Busy, Done,
           Err_Full, Err_Index, Drop
  );

  modport slave (
    input  Add_Pulse, Cancel_Pulse, Clear_Pulse, ProductID_in, ProductQuantity_in,
           Cancel_Index, Rd_Index,
    output Rd_ProductID, Rd_Quantity, Rd_Valid, BasketProductNum, Busy, Done,
           Err_Full, Err_Index, Drop
  );
endinterface

// File: rtl/basket_controller.sv
// Compacted (ID, qty) basket store; sequences Add/Cancel/Clear pulses into multi-cycle
// search/merge/append/shift operations and exposes a registered display read port.
module basket_controller #(
  parameter int MAX_ITEMS = 8,
  parameter int QTY_MAX   = 15
) (
  input logic          CLOCK_50,
  input logic          RESET,
  basket_controller_if.slave bif
);
  typedef struct packed {
    logic [3:0] id;
    logic [3:0] qty;
  } entry_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEARCH = 3'd1;
  localparam logic [2:0] MERGE  = 3'd2;
  localparam logic [2:0] APPEND = 3'd3;
  localparam logic [2:0] SHIFT  = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;
  localparam logic [2:0] CLEAR  = 3'd6;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ITEMS);
  localparam logic [4:0] QTY_SAT = 5'(QTY_MAX);

  logic [2:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] id_q, id_d;
  logic [3:0] qin_q, qin_d;
  logic [3:0] count_q, count_d;
  entry_t     ent_q [16];
  entry_t     ent_d [16];
  logic       full_flag_q, full_flag_d;
  logic       idx_flag_q, idx_flag_d;
  logic       done_q, done_d;
  logic       err_full_q, err_full_d;
  logic       err_index_q, err_index_d;
  logic       drop_q, drop_d;
  logic [3:0] rd_id_q, rd_id_d;
  logic [3:0] rd_qty_q, rd_qty_d;
  logic       rd_vld_q, rd_vld_d;

  logic [4:0] qty_sum;
  logic [3:0] idx_inc;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    id_d        = id_q;
    qin_d       = qin_q;
    count_d     = count_q;
    ent_d       = ent_q;
    full_flag_d = full_flag_q;
    idx_flag_d  = idx_flag_q;
    done_d      = 1'b0;
    err_full_d  = 1'b0;
    err_index_d = 1'b0;
    drop_d      = (state_q != IDLE) &&
                  (bif.Add_Pulse || bif.Cancel_Pulse || bif.Clear_Pulse);
    idx_inc     = idx_q + 4'd1;
    qty_sum     = {1'b0, ent_q[idx_q].qty} + {1'b0, qin_q};

    case (state_q)
      IDLE: begin
        full_flag_d = 1'b0;
        idx_flag_d  = 1'b0;
        if (bif.Clear_Pulse) begin
          state_d = CLEAR;
        end else if (bif.Cancel_Pulse) begin
          if (bif.Cancel_Index >= count_q) begin
            idx_flag_d = 1'b1;
            state_d    = FINISH;
          end else begin
            idx_d   = bif.Cancel_Index;
            state_d = SHIFT;
          end
        end else if (bif.Add_Pulse) begin
          id_d  = bif.ProductID_in;
          qin_d = bif.ProductQuantity_in;
          idx_d = 4'd0;
          if (bif.ProductQuantity_in == 4'd0) state_d = FINISH;
          else if (count_q == 4'd0)           state_d = APPEND;
          else                                state_d = SEARCH;
        end
      end
      SEARCH: begin
        // The scan steps one past the last entry before declaring a miss.
        if (idx_q == count_q) begin
          if (count_q < MAX_CNT) begin
            state_d = APPEND;
          end else begin
            full_flag_d = 1'b1;
            state_d     = FINISH;
          end
        end else if (ent_q[idx_q].id == id_q) begin
          state_d = MERGE;
        end else begin
          idx_d = idx_inc;
        end
      end
      MERGE: begin
        ent_d[idx_q].qty = (qty_sum > QTY_SAT) ? QTY_SAT[3:0] : qty_sum[3:0];
        state_d          = FINISH;
      end
      APPEND: begin
        ent_d[count_q] = '{id: id_q, qty: qin_q};
        count_d        = count_q + 4'd1;
        state_d        = FINISH;
      end
      SHIFT: begin
        // After the tail is zeroed idx sits one past the shrunken count.
        if (idx_q >= count_q) begin
          state_d = FINISH;
        end else if (idx_q < count_q - 4'd1) begin
          ent_d[idx_q] = ent_q[idx_inc];
          idx_d        = idx_inc;
        end else begin
          ent_d[idx_q] = '0;
          count_d      = count_q - 4'd1;
          idx_d        = idx_inc;
        end
      end
      CLEAR: begin
        ent_d   = '{default: '0};
        count_d = 4'd0;
        state_d = FINISH;
      end
      FINISH: begin
        done_d      = 1'b1;
        err_full_d  = full_flag_q;
        err_index_d = idx_flag_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d = bif.Rd_Index < count_q;
    rd_id_d  = ent_q[bif.Rd_Index].id;
    rd_qty_d = ent_q[bif.Rd_Index].qty;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      id_q        <= '0;
      qin_q       <= '0;
      count_q     <= '0;
      ent_q       <= '{default: '0};
      full_flag_q <= 1'b0;
      idx_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      err_full_q  <= 1'b0;
      err_index_q <= 1'b0;
      drop_q      <= 1'b0;
      rd_id_q     <= '0;
      rd_qty_q    <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      qin_q       <= qin_d;
      count_q     <= count_d;
      ent_q       <= ent_d;
      full_flag_q <= full_flag_d;
      idx_flag_q  <= idx_flag_d;
      done_q      <= done_d;
      err_full_q  <= err_full_d;
      err_index_q <= err_index_d;
      drop_q      <= drop_d;
      rd_id_q     <= rd_id_d;
      rd_qty_q    <= rd_qty_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign bif.Rd_ProductID     = rd_id_q;
  assign bif.Rd_Quantity      = rd_qty_q;
  assign bif.Rd_Valid         = rd_vld_q;
  assign bif.BasketProductNum = count_q;
  assign bif.Busy             = (state_q != IDLE);
  assign bif.Done             = done_q;
  assign bif.Err_Full         = err_full_q;
  assign bif.Err_Index        = err_index_q;
  assign bif.Drop             = drop_q;
endmodule

// File: tb/tb_basket_controller.sv
// Randomized scoreboard bench for basket_controller: a list-based basket model predicts
// completion latency, errors, count, drops and read-port contents.
module tb_basket_controller;
  localparam int MAXI = 8;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  always #5 CLOCK_50 = ~CLOCK_50;

  basket_controller_if bif();
  basket_controller #(.MAX_ITEMS(MAXI), .QTY_MAX(15)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .bif(bif)
  );

  typedef struct { int lat; int ef; int ei; int cnt; int acc; } exp_t;
  typedef struct { int v; int id; int q; } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   drop_q[$];
  int   m_id[$];
  int   m_qty[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rd_tag  = 1'b0;
  logic rd_pend = 1'b0;
  exp_t me;
  rd_t  mr;
  int   md;

  always @(posedge CLOCK_50) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_tag;
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge CLOCK_50) begin
    if (RESET !== 1'b1) begin
      if (bif.Done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check("latency", cyc - me.acc, me.lat);
          check("err_full", int'(bif.Err_Full), me.ef);
          check("err_index", int'(bif.Err_Index), me.ei);
          check("count", int'(bif.BasketProductNum), me.cnt);
        end
      end else begin
        check("err_without_done", int'(bif.Err_Full | bif.Err_Index), 0);
      end
      if (bif.Drop === 1'b1) begin
        if (drop_q.size() == 0) check("unexpected_drop", 1, 0);
        else begin
          md = drop_q.pop_front();
          check("drop_cycle", cyc, md);
        end
      end
      if (rd_pend === 1'b1 && rd_q.size() != 0) begin
        mr = rd_q.pop_front();
        check("rd_valid", int'(bif.Rd_Valid), mr.v);
        check("rd_id", int'(bif.Rd_ProductID), mr.id);
        check("rd_qty", int'(bif.Rd_Quantity), mr.q);
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  // Reference model: apply one command to the list, return latency and flags.
  task automatic model(input bit add, input bit cancel, input bit clear, input int id,
                       input int q, input int ci, output exp_t e);
    int sz, pos;
    sz = m_id.size();
    e.ef = 0; e.ei = 0;
    if (clear) begin
      m_id.delete(); m_qty.delete(); e.lat = 2;
    end else if (cancel) begin
      if (ci >= sz) begin e.ei = 1; e.lat = 1; end
      else begin
        e.lat = (sz - 1 - ci) + 3;
        m_id.delete(ci); m_qty.delete(ci);
      end
    end else begin
      pos = -1;
      for (int k = 0; k < sz; k++) if (pos < 0 && m_id[k] == id) pos = k;
      if (q == 0) e.lat = 1;
      else if (pos >= 0) begin
        e.lat = pos + 3;
        m_qty[pos] = (m_qty[pos] + q > 15) ? 15 : m_qty[pos] + q;
      end else if (sz < MAXI) begin
        e.lat = (sz == 0) ? 2 : sz + 3;
        m_id.push_back(id); m_qty.push_back(q);
      end else begin
        e.ef = 1; e.lat = sz + 2;
      end
    end
    e.cnt = m_id.size();
  endtask

  task automatic issue(input bit add, input bit cancel, input bit clear, input int id,
                       input int q, input int ci, input bit inj_drop);
    exp_t e;
    bif.Add_Pulse          = add;
    bif.Cancel_Pulse       = cancel;
    bif.Clear_Pulse        = clear;
    bif.ProductID_in       = 4'(id);
    bif.ProductQuantity_in = 4'(q);
    bif.Cancel_Index       = 4'(ci);
    model(add, cancel, clear, id, q, ci, e);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    tick();
    bif.Add_Pulse = 1'b0; bif.Cancel_Pulse = 1'b0; bif.Clear_Pulse = 1'b0;
    if (inj_drop) begin
      bif.Add_Pulse          = 1'b1;
      bif.ProductID_in       = 4'd13;
      bif.ProductQuantity_in = 4'd7;
      drop_q.push_back(cyc + 1);
      tick();
      bif.Add_Pulse = 1'b0;
    end
    wait_done();
  endtask

  task automatic read_sweep();
    rd_t r;
    for (int k = 0; k < 16; k++) begin
      bif.Rd_Index = 4'(k);
      rd_tag = 1'b1;
      if (k < m_id.size()) begin r.v = 1; r.id = m_id[k]; r.q = m_qty[k]; end
      else begin r.v = 0; r.id = 0; r.q = 0; end
      rd_q.push_back(r);
      tick();
    end
    rd_tag = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"}, int'(bif.BasketProductNum), 0);
    check({tag, "_busy"}, int'(bif.Busy), 0);
    check({tag, "_done"}, int'(bif.Done), 0);
    check({tag, "_rdvalid"}, int'(bif.Rd_Valid), 0);
    check({tag, "_rddata"}, int'({bif.Rd_ProductID, bif.Rd_Quantity}), 0);
    check({tag, "_flags"}, int'({bif.Err_Full, bif.Err_Index, bif.Drop}), 0);
  endtask

  initial begin
    int r;
    bif.Add_Pulse = 1'b0; bif.Cancel_Pulse = 1'b0; bif.Clear_Pulse = 1'b0;
    bif.ProductID_in = '0; bif.ProductQuantity_in = '0;
    bif.Cancel_Index = '0; bif.Rd_Index = '0;
    RESET = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    RESET = 1'b0;
    tick();
    read_sweep();

    issue(1, 0, 0, 3, 2, 0, 0);
    read_sweep();
    issue(1, 0, 0, 5, 1, 0, 0);
    issue(1, 0, 0, 5, 4, 0, 0);
    read_sweep();

    issue(0, 0, 1, 0, 0, 0, 0);
    issue(1, 0, 0, 3, 14, 0, 0);
    issue(1, 0, 0, 3, 4, 0, 0);
    read_sweep();

    issue(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < MAXI; k++) issue(1, 0, 0, k, 1, 0, 0);
    issue(1, 0, 0, 9, 1, 0, 0);
    read_sweep();

    issue(0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) issue(1, 0, 0, k, k, 0, 0);
    issue(0, 1, 0, 0, 0, 1, 1);
    read_sweep();
    issue(0, 1, 0, 0, 0, 3, 0);
    issue(1, 0, 0, 6, 0, 0, 0);
    issue(1, 0, 1, 7, 3, 0, 0);
    read_sweep();
    issue(1, 0, 0, 2, 2, 0, 0);
    issue(1, 1, 0, 4, 4, 0, 0);
    read_sweep();

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)
        issue(1, 0, 0, int'($urandom_range(0, 11)), int'($urandom_range(0, 15)), 0, ($urandom_range(0, 3) == 0));
      else if (r < 17)
        issue(0, 1, 0, 0, 0, int'($urandom_range(0, m_id.size() + 1)), ($urandom_range(0, 3) == 0));
      else if (r < 18)
        issue(0, 0, 1, 0, 0, 0, 0);
      else
        issue(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
              int'($urandom_range(1, 15)), int'($urandom_range(0, 7)), 0);
      if (n % 8 == 7) read_sweep();
    end
    read_sweep();

    issue(0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) issue(1, 0, 0, k, k, 0, 0);
    bif.Cancel_Pulse = 1'b1; bif.Cancel_Index = 4'd0;
    tick();
    bif.Cancel_Pulse = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    check_all_zero("reset_mid_shift");
    exp_q.delete();
    m_id.delete(); m_qty.delete();
    tick();
    RESET = 1'b0;
    repeat (10) tick();
    read_sweep();
    check("drops_outstanding", drop_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
